// File: rtl/rr_mux_reg.sv
// Registered N-to-1 channel mux with valid/ready handshake.
// Mode 0 forwards the channel picked by sel; mode 1 arbitrates round-robin over valid channels.
module rr_mux_reg #(
  parameter int unsigned data_bits = 8,
  parameter int unsigned sel_bits  = 2,
  localparam int unsigned N        = 2 ** sel_bits
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0][data_bits-1:0]   data_in,
  input  logic [N-1:0]                  in_valid,
  output logic [N-1:0]                  in_ready,
  input  logic [sel_bits-1:0]           sel,
  input  logic                          mode,
  output logic [data_bits-1:0]          data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [sel_bits-1:0]           out_sel
);

  logic [data_bits-1:0] data_q;
  logic                 valid_q;
  logic [sel_bits-1:0]  sel_q;
  logic [sel_bits-1:0]  ptr_q;

  logic                 load;
  logic                 grant;
  logic [sel_bits-1:0]  g;
  logic [sel_bits-1:0]  idx;

  assign load = !valid_q || out_ready;

  always_comb begin
    grant = 1'b0;
    g     = '0;
    idx   = '0;
    if (!mode) begin
      if (in_valid[sel]) begin
        grant = 1'b1;
        g     = sel;
      end
    end else begin
      // Search starts at ptr and wraps naturally via the sel_bits-wide sum.
      for (int k = 0; k < N; k++) begin
        idx = ptr_q + sel_bits'(k);
        if (!grant && in_valid[idx]) begin
          grant = 1'b1;
          g     = idx;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && load && grant && (g == sel_bits'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      if (grant) begin
        data_q  <= data_in[g];
        sel_q   <= g;
        valid_q <= 1'b1;
        ptr_q   <= g + 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: reset, fixed select, round-robin, sparse valids,
// backpressure and an invalid fixed selection.
module tb_rr_mux_reg;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0][7:0]  data_in;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [1:0]       sel;
  logic             mode;
  logic [7:0]       data_out;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_sel;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] exp_data [4] = '{8'h88, 8'h00, 8'hF0, 8'hFF};

  rr_mux_reg #(.data_bits(8), .sel_bits(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    data_in   = {8'hFF, 8'hF0, 8'h00, 8'h88};
    in_valid  = 4'hF;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    nvec++;
    if (data_out !== 8'h00) begin
      nerr++; $display("FAIL reset_data got %h want 00", data_out);
    end
    nvec++;
    if (in_ready !== 4'h0) begin
      nerr++; $display("FAIL reset_in_ready got %b want 0000", in_ready);
    end
    nvec++;
    if (out_sel !== 2'd0) begin
      nerr++; $display("FAIL reset_out_sel got %0d want 0", out_sel);
    end
    rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0001) begin
      nerr++; $display("FAIL post_reset_in_ready got %b want 0001", in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || data_out !== 8'h88) begin
      nerr++;
      $display("FAIL post_reset_grant got v=%b sel=%0d d=%h want v=1 sel=0 d=88",
               out_valid, out_sel, data_out);
    end
    // Asynchronous reset mid-stream drops the held word immediately.
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || data_out !== 8'h00) begin
      nerr++; $display("FAIL mid_reset got v=%b d=%h want v=0 d=00", out_valid, data_out);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    nvec++;
    if (out_sel !== 2'd0 || data_out !== 8'h88) begin
      nerr++; $display("FAIL mid_reset_restart got sel=%0d d=%h want sel=0 d=88",
                       out_sel, data_out);
    end
  endtask

  task automatic test_mode0();
    do_reset();
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i) || data_out !== exp_data[i]) begin
        nerr++;
        $display("FAIL mode0[%0d] got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h",
                 i, out_valid, out_sel, data_out, i, exp_data[i]);
      end
    end
  endtask

  task automatic test_mode1();
    do_reset();
    mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || data_out !== exp_data[i % 4]) begin
        nerr++;
        $display("FAIL rr[%0d] got sel=%0d d=%h want sel=%0d d=%h",
                 i, out_sel, data_out, i % 4, exp_data[i % 4]);
      end
    end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_g [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (in_ready !== (4'b0001 << exp_g[i])) begin
        nerr++;
        $display("FAIL sparse_ready[%0d] got %b want %b", i, in_ready, 4'b0001 << exp_g[i]);
      end
      tick();
      nvec++;
      if (out_sel !== exp_g[i] || data_out !== exp_data[exp_g[i]]) begin
        nerr++;
        $display("FAIL sparse_grant[%0d] got sel=%0d d=%h want sel=%0d d=%h",
                 i, out_sel, data_out, exp_g[i], exp_data[exp_g[i]]);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    tick();
    nvec++;
    if (out_valid !== 1'b1 || data_out !== 8'hF0) begin
      nerr++; $display("FAIL bp_load got v=%b d=%h want v=1 d=F0", out_valid, data_out);
    end
    // ptr is now 3; switching modes/sel during the stall must not touch the held word.
    out_ready = 1'b0; mode = 1'b1; sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++;
      if (in_ready !== 4'h0) begin
        nerr++; $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready);
      end
      tick();
      nvec++;
      if (out_valid !== 1'b1 || data_out !== 8'hF0 || out_sel !== 2'd2) begin
        nerr++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h sel=%0d want v=1 d=F0 sel=2",
                 i, out_valid, data_out, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b1000) begin
      nerr++; $display("FAIL bp_release_ready got %b want 1000", in_ready);
    end
    tick();
    nvec++;
    if (out_sel !== 2'd3 || data_out !== 8'hFF) begin
      nerr++; $display("FAIL bp_release got sel=%0d d=%h want sel=3 d=FF", out_sel, data_out);
    end
  endtask

  task automatic test_sel_invalid();
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
    tick();
    sel = 2'd2; in_valid = 4'b1011; out_ready = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 4'h0) begin
      nerr++; $display("FAIL inv_stall_ready got %b want 0000", in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || data_out !== 8'h00 || out_sel !== 2'd1) begin
      nerr++; $display("FAIL inv_hold got v=%b d=%h sel=%0d want v=1 d=00 sel=1",
                       out_valid, data_out, out_sel);
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'h0) begin
      nerr++; $display("FAIL inv_ready got %b want 0000", in_ready);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || data_out !== 8'h00 || out_sel !== 2'd1) begin
      nerr++; $display("FAIL inv_drain got v=%b d=%h sel=%0d want v=0 d=00 sel=1",
                       out_valid, data_out, out_sel);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL inv_idle got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; data_in = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
    #2;
    test_reset();
    test_mode0();
    test_mode1();
    test_sparse();
    test_back_pressure();
    test_sel_invalid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
